// File: rtl/registers_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : registers_dump_ctrl
// Brief    : Walks a register bank and streams every register, LSB byte first,
//            over a valid/ready byte interface.
// Revision : 1.0 - initial release
// ============================================================================
module registers_dump_ctrl #(
    parameter int REGISTERS_BANK_SIZE = 32,
    parameter int REGISTERS_SIZE      = 32
) (
    input  logic                                   i_clk,
    input  logic                                   i_reset,
    input  logic                                   i_start,
    input  logic                                   i_abort,
    output logic [$clog2(REGISTERS_BANK_SIZE)-1:0] o_rd_addr,
    input  logic [REGISTERS_SIZE-1:0]              i_rd_data,
    output logic [7:0]                             o_byte,
    output logic                                   o_byte_valid,
    input  logic                                   i_byte_ready,
    output logic                                   o_busy,
    output logic                                   o_done
);

    localparam int c_BYTES  = REGISTERS_SIZE / 8;
    localparam int c_ADDR_W = $clog2(REGISTERS_BANK_SIZE);
    localparam int c_CNT_W  = (c_BYTES > 1) ? $clog2(c_BYTES) : 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FETCH = 2'd1;
    localparam logic [1:0] c_SEND  = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [c_ADDR_W-1:0] c_LAST_ADDR = c_ADDR_W'(REGISTERS_BANK_SIZE - 1);
    localparam logic [c_CNT_W-1:0]  c_LAST_BYTE = c_CNT_W'(c_BYTES - 1);

    logic [1:0]                r_state;
    logic [1:0]                w_state_next;
    logic [c_ADDR_W-1:0]       r_addr;
    logic [c_CNT_W-1:0]        r_byte_cnt;
    logic [REGISTERS_SIZE-1:0] r_shift;

    logic w_abort;
    logic w_xfer;
    logic w_last_byte;
    logic w_last_addr;

    // Abort masks the handshake in the same cycle, so it always wins over a transfer.
    assign w_abort     = i_abort && (r_state != c_IDLE);
    assign w_xfer      = (r_state == c_SEND) && !i_abort && i_byte_ready;
    assign w_last_byte = (r_byte_cnt == c_LAST_BYTE);
    assign w_last_addr = (r_addr == c_LAST_ADDR);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (i_start) begin
                    w_state_next = c_FETCH;
                end
            end
            c_FETCH: begin
                w_state_next = w_abort ? c_IDLE : c_SEND;
            end
            c_SEND: begin
                if (w_abort) begin
                    w_state_next = c_IDLE;
                end else if (w_xfer && w_last_byte) begin
                    w_state_next = w_last_addr ? c_DONE : c_FETCH;
                end
            end
            c_DONE: begin
                w_state_next = c_IDLE;
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    always_comb begin
        o_busy       = (r_state != c_IDLE);
        o_byte_valid = (r_state == c_SEND) && !i_abort;
        o_done       = (r_state == c_DONE) && !i_abort;
    end

    assign o_byte    = r_shift[7:0];
    assign o_rd_addr = r_addr;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_addr     <= '0;
            r_byte_cnt <= '0;
            r_shift    <= '0;
        end else if (w_abort) begin
            r_addr     <= '0;
            r_byte_cnt <= '0;
            r_shift    <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (i_start) begin
                        r_addr     <= '0;
                        r_byte_cnt <= '0;
                    end
                end
                c_FETCH: begin
                    r_shift    <= i_rd_data;
                    r_byte_cnt <= '0;
                end
                c_SEND: begin
                    if (w_xfer) begin
                        r_shift    <= r_shift >> 8;
                        r_byte_cnt <= r_byte_cnt + c_CNT_W'(1);
                        // The address stops at the last register so it never wraps.
                        if (w_last_byte && !w_last_addr) begin
                            r_addr <= r_addr + c_ADDR_W'(1);
                        end
                    end
                end
                c_DONE: begin
                    r_addr <= '0;
                end
                default: begin
                    r_addr <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/registers_dump_ctrl.md
REGISTERS_DUMP_CTRL -- requirements
Module: registers_dump_ctrl

Interface
REQ-001 Parameter REGISTERS_BANK_SIZE, default 32, number of registers to dump; the block SHALL support any value >= 2.
REQ-002 Parameter REGISTERS_SIZE, default 32, register width in bits; the block SHALL support any multiple of 8; BYTES = REGISTERS_SIZE/8.
REQ-003 i_clk  input  1  single clock; all state SHALL change on the rising edge.
REQ-004 i_reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-005 i_start  input  1  request a full bank dump; sampled in IDLE only.
REQ-006 i_abort  input  1  synchronous cancel of a dump in progress.
REQ-007 o_rd_addr  output  $clog2(REGISTERS_BANK_SIZE)  drives the bank's combinational read port.
REQ-008 i_rd_data  input  REGISTERS_SIZE  read data for o_rd_addr, valid in the same cycle.
REQ-009 o_byte  output  8  byte toward the serial transmitter.
REQ-010 o_byte_valid  output  1  o_byte holds a byte to transfer.
REQ-011 i_byte_ready  input  1  transmitter accepts; transfer = o_byte_valid && i_byte_ready at a rising edge.
REQ-012 o_busy  output  1  high in any state other than IDLE.
REQ-013 o_done  output  1  one-cycle pulse after the last byte of a completed dump.

Function
REQ-014 The FSM SHALL have the states IDLE, FETCH, SEND and DONE.
REQ-015 IDLE: on i_start=1 -> FETCH with address counter = 0; otherwise stay in IDLE.
REQ-016 FETCH: the block SHALL load a shift register from i_rd_data, clear the byte counter and go to SEND after exactly one cycle.
REQ-017 SEND: o_byte_valid SHALL be 1 and o_byte = shift register [7:0]; registers SHALL be sent LSB byte first.
REQ-018 SEND: on a transfer, the shift register SHALL shift right by 8 and the byte counter SHALL increment.
REQ-019 SEND: on the transfer of byte BYTES-1, if address = REGISTERS_BANK_SIZE-1 the FSM SHALL go to DONE; otherwise the address SHALL increment and the FSM SHALL go to FETCH.
REQ-020 While o_byte_valid=1 and i_byte_ready=0, o_byte and o_byte_valid SHALL hold unchanged (no retraction).
REQ-021 DONE: o_done=1 for exactly one cycle, then -> IDLE.
REQ-022 o_byte_valid SHALL be 0 in IDLE, FETCH and DONE.
REQ-023 o_rd_addr SHALL equal the address counter in every state; the counter SHALL never exceed REGISTERS_BANK_SIZE-1 and SHALL never wrap.
REQ-024 i_start SHALL be ignored while o_busy=1; a new dump requires a new i_start in IDLE.
REQ-025 i_abort=1 in FETCH, SEND or DONE SHALL force IDLE on the next edge, clear the address counter and produce no o_done pulse; abort takes priority over a simultaneous transfer.
REQ-026 An abort in SEND SHALL drop o_byte_valid without a transfer; this is the only permitted handshake retraction.
REQ-027 Simultaneous i_start and i_abort in IDLE SHALL start a dump (abort has no effect in IDLE).
REQ-028 With i_byte_ready held at 1, a dump SHALL take REGISTERS_BANK_SIZE*(1+BYTES) cycles from the FETCH entry to the DONE entry (160 cycles at default parameters).
REQ-029 Total bytes emitted per completed dump SHALL be REGISTERS_BANK_SIZE*BYTES (128 at default parameters).

Reset
REQ-030 i_reset=0 SHALL immediately, without waiting for a clock edge, force IDLE, address = 0, byte counter = 0, shift register = 0, o_byte = 0, o_byte_valid = 0, o_busy = 0 and o_done = 0.
REQ-031 Reset asserted mid-dump SHALL discard the dump; after release the block SHALL wait in IDLE for i_start.
REQ-032 The first rising edge after reset release SHALL already be able to sample i_start.

Verification
REQ-033 Defaults, bank reg[k] = 0x1000_0000+k, ready=1, one i_start pulse -> bytes 00 00 00 10 01 00 00 10 ... 1F 00 00 10; o_done at the 161st cycle after the start edge.
REQ-034 Random i_byte_ready with 30% duty -> byte sequence identical to REQ-033; o_byte stable throughout every stall; exactly 128 transfers; one o_done pulse.
REQ-035 i_abort during byte 2 of reg 5 -> o_byte_valid=0 and o_busy=0 the next cycle, no o_done, o_rd_addr=0; a new i_start then restarts at reg 0 byte 0.
REQ-036 Asynchronous reset asserted between edges mid-SEND -> o_byte_valid and o_busy go 0 before the next edge; no output change until a new i_start after release.
REQ-037 i_start held high for the whole dump plus 3 cycles -> exactly one dump per IDLE visit; a second dump begins the cycle after DONE.
REQ-038 REGISTERS_BANK_SIZE=4, REGISTERS_SIZE=8, ready=1 -> 4 bytes, o_rd_addr sequence 0,1,2,3, o_done 8 cycles after FETCH entry.
